button_event_encoder: RTL and testbench

Sits directly downstream of the four per-button debouncers in the Simon game and upstream of the game controller FSM. Converts four debounced button levels into discrete press events, each carrying a 2-bit button code. Events are buffered in a small FIFO and handed to the controller over a valid/ready handshake, so presses made while the controller is busy are not lost.

---
 rtl/button_event_encoder.sv | 216 +++++++++++++++++++++
 tb/tb_button_event_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_encoder.sv
// -----------------------------------------------------------------------------
// button_event_encoder
//
// Purpose:
//   Turns four debounced button levels into discrete press events, each
//   carrying a 2-bit button code. Events are queued in a small FIFO and
//   handed to the game controller over a valid/ready handshake, so presses
//   made while the controller is busy are not lost.
//
// Configuration macro:
//   BTN_EVT_LOCKOUT_EN  defined     -> lockout FSM present. Only one event is
//                                      produced per press-and-release-all cycle.
//                       not defined -> no FSM and busy is tied 0. Every
//                                      qualified rising edge is accepted.
//
// Parameters:
//   DEPTH     FIFO entries; a power of two, >= 2.
//
// Ports:
//   clock     in   1                system clock, rising edge
//   reset_n   in   1                synchronous, active-low reset
//   btn       in   4                debounced levels; index = button code
//   enable    in   1                high = accept new presses
//   flush     in   1                empty the FIFO and clear overflow
//   ev_ready  in   1                consumer accepts the head event
//   ev_valid  out  1                FIFO not empty
//   ev_code   out  2                code at the FIFO head (registered)
//   ev_count  out  log2(DEPTH)+1    number of entries held
//   overflow  out  1                sticky; a press was dropped because full
//   busy      out  1                lockout FSM in HELD
// -----------------------------------------------------------------------------
module button_event_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [3:0]               btn,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     ev_ready,
   output logic                     ev_valid,
   output logic [1:0]               ev_code,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow,
   output logic                     busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // ---------------------------------------------------------------------
   // Edge detection and priority encoding
   // ---------------------------------------------------------------------
   logic [3:0] btn_prev_q;
   logic [3:0] rise;
   logic [1:0] push_code;

   assign rise = btn & ~btn_prev_q;

   // Lowest index wins; the scan runs high to low so the last hit is lowest.
   always_comb begin
      push_code = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rise[i]) begin
            push_code = i[1:0];
         end
      end
   end

   // Reset loads all ones so a button held through reset does not look like
   // a fresh press on the first cycle after reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         btn_prev_q <= 4'b1111;
      end else begin
         btn_prev_q <= btn;
      end
   end

   // ---------------------------------------------------------------------
   // Lockout FSM
   // ---------------------------------------------------------------------
   logic lockout_idle;
   logic accept;

   assign accept = (|rise) && enable && !flush && lockout_idle;

`ifdef BTN_EVT_LOCKOUT_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HELD = 1'b1;

   logic [0:0] state_q;
   logic [0:0] state_d;

   // Release is checked regardless of enable/flush so a held lockout always
   // clears once every button is up.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)        state_d = ST_HELD;
         ST_HELD: if (btn == 4'b0000) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign lockout_idle = (state_q == ST_IDLE);
   assign busy         = (state_q == ST_HELD);
`else
   assign lockout_idle = 1'b1;
   assign busy         = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   logic [1:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_inc;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          overflow_q;
   logic [1:0]    head_q;
   logic [1:0]    head_d;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CW'(DEPTH));
   assign pop        = ev_ready && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still push.
   assign push       = accept && (!full || pop);
   assign drop       = accept && full && !pop;
   assign rd_ptr_inc = rd_ptr_q + PW'(1);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // The head is kept in its own register so a freshly pushed code is on
   // ev_code one edge after the press. When popping with two or more entries
   // the next head is already in storage at rd+1 (never the slot being
   // written this cycle); otherwise it is the code being pushed.
   always_comb begin
      head_d = head_q;
      if (pop) begin
         if (count_q > CW'(1)) begin
            head_d = mem_q[rd_ptr_inc];
         end else if (push) begin
            head_d = push_code;
         end
      end else if (empty && push) begin
         head_d = push_code;
      end
   end

   // Storage has no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_code;
      end
   end

   // flush never coincides with push (accept is gated by it) and overrides a
   // same-cycle pop.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         head_q     <= 2'd0;
      end else if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         head_q     <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_inc;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

   assign ev_valid = !empty;
   assign ev_code  = head_q;
   assign ev_count = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_encoder
//
// Self-checking bench for button_event_encoder (DEPTH = 4). A queue-based
// reference model tracks the event stream, the sticky overflow bit and the
// lockout state; every cycle of each scenario is compared against it, and
// the directed scenarios add fixed expected values on top.
// Honours BTN_EVT_LOCKOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_button_event_encoder;

   localparam int DEPTH = 4;

   logic       clock    = 1'b0;
   logic       reset_n  = 1'b0;
   logic [3:0] btn      = 4'b0000;
   logic       enable   = 1'b1;
   logic       flush    = 1'b0;
   logic       ev_ready = 1'b0;

   logic       ev_valid;
   logic [1:0] ev_code;
   logic [2:0] ev_count;
   logic       overflow;
   logic       busy;

   int total  = 0;
   int passed = 0;

   // reference model state
   int unsigned m_q[$];
   bit          m_ovf;
   bit          m_held;
   logic [3:0]  m_prev;

   logic [7:0]  obs;
   logic [7:0]  exp_v;

   button_event_encoder #(.DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .btn      (btn),
      .enable   (enable),
      .flush    (flush),
      .ev_ready (ev_ready),
      .ev_valid (ev_valid),
      .ev_code  (ev_code),
      .ev_count (ev_count),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   // Behavioural model of one clock edge, using the inputs sampled there.
   task automatic model_edge();
      logic [3:0] rises;
      bit         do_pop;
      bit         acc;
      int         code;
      if (!reset_n) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_held = 1'b0;
         m_prev = 4'b1111;
         return;
      end
      rises  = btn & ~m_prev;
      do_pop = (m_q.size() != 0) && ev_ready;
      acc    = (rises != 4'b0000) && enable && !flush && !m_held;
      code   = 0;
      for (int i = 3; i >= 0; i--) begin
         if (rises[i]) code = i;
      end
      if (flush) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (acc) begin
            if (m_q.size() < DEPTH) m_q.push_back(code);
            else                    m_ovf = 1'b1;
         end
      end
`ifdef BTN_EVT_LOCKOUT_EN
      if (m_held && btn == 4'b0000) m_held = 1'b0;
      else if (acc)                 m_held = 1'b1;
`endif
      m_prev = btn;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   function automatic logic [7:0] pack_obs();
      return {ev_valid, (ev_valid ? ev_code : 2'b00), ev_count, overflow, busy};
   endfunction

   function automatic logic [7:0] pack_exp();
      int n;
      logic [1:0] hd;
      n  = m_q.size();
      hd = 2'b00;
      if (n != 0) hd = 2'(m_q[0]);
      return {(n != 0), hd, 3'(n), m_ovf, m_held};
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0; btn = 4'b0100;
      step();
      total++;
      if (pack_obs() !== 8'h00)
         $display("FAIL reset_state: got %b expected %b", pack_obs(), 8'h00);
      else passed++;
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         btn = (c < 3) ? 4'b0100 : ((c == 3) ? 4'b0000 : 4'b0100);
         step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v)
            $display("FAIL reset_held cyc%0d: got %b expected %b", c, obs, exp_v);
         else passed++;
      end
      total++;
      if (ev_valid !== 1'b1 || ev_code !== 2'd2)
         $display("FAIL reset_repress: got valid=%b code=%0d expected valid=1 code=2",
                  ev_valid, ev_code);
      else passed++;
      $display("reset: re-press event code=%0d", ev_code);
      btn = 4'b0000; flush = 1'b1; step(); flush = 1'b0; step();
   endtask

   task automatic test_order();
      int codes[4] = '{0, 3, 1, 2};
      logic [1:0] want;
      ev_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         btn = k[0] ? 4'b0000 : (4'b0001 << codes[k/2]);
         step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v)
            $display("FAIL order_fill step%0d: got %b expected %b", k, obs, exp_v);
         else passed++;
      end
      total++;
      if (ev_count !== 3'd4)
         $display("FAIL order_count: got %0d expected 4", ev_count);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         want = 2'(codes[k]);
         total++;
         if (ev_valid !== 1'b1 || ev_code !== want || ev_count !== 3'(4 - k))
            $display("FAIL order_pop%0d: got code=%0d count=%0d expected code=%0d count=%0d",
                     k, ev_code, ev_count, want, 4 - k);
         else passed++;
         $display("order: pop code=%0d", ev_code);
         ev_ready = 1'b1; step(); ev_ready = 1'b0; step();
      end
      total++;
      if (ev_count !== 3'd0 || ev_valid !== 1'b0 || overflow !== 1'b0)
         $display("FAIL order_drain: got count=%0d valid=%b ovf=%b expected 0/0/0",
                  ev_count, ev_valid, overflow);
      else passed++;
   endtask

   task automatic test_overflow_flush();
      int seq[5] = '{0, 1, 2, 3, 1};
      ev_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         btn = k[0] ? 4'b0000 : (4'b0001 << seq[k/2]);
         step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v)
            $display("FAIL ovf_fill step%0d: got %b expected %b", k, obs, exp_v);
         else passed++;
      end
      total++;
      if (overflow !== 1'b1 || ev_count !== 3'd4 || ev_code !== 2'd0)
         $display("FAIL ovf_full: got ovf=%b count=%0d head=%0d expected 1/4/0",
                  overflow, ev_count, ev_code);
      else passed++;
      $display("overflow: count=%0d ovf=%b", ev_count, overflow);
      // full with same-cycle pop and push: push succeeds, count stays at DEPTH
      btn = 4'b1000; ev_ready = 1'b1; step(); ev_ready = 1'b0;
      total++;
      if (ev_count !== 3'd4 || ev_code !== 2'd1)
         $display("FAIL full_pushpop: got count=%0d head=%0d expected 4/1", ev_count, ev_code);
      else passed++;
      btn = 4'b0000; flush = 1'b1; ev_ready = 1'b1; step(); flush = 1'b0; ev_ready = 1'b0;
      total++;
      if (ev_count !== 3'd0 || overflow !== 1'b0 || ev_valid !== 1'b0)
         $display("FAIL flush: got count=%0d ovf=%b valid=%b expected 0/0/0",
                  ev_count, overflow, ev_valid);
      else passed++;
      step();
   endtask

   task automatic test_simultaneous();
      btn = 4'b1010; step();
      total++;
      if (ev_valid !== 1'b1 || ev_code !== 2'd1 || ev_count !== 3'd1)
         $display("FAIL simul: got valid=%b code=%0d count=%0d expected 1/1/1",
                  ev_valid, ev_code, ev_count);
      else passed++;
      $display("simultaneous: code=%0d", ev_code);
      btn = 4'b0000; step();
      obs = pack_obs(); exp_v = pack_exp();
      total++;
      if (obs !== exp_v || ev_count !== 3'd1)
         $display("FAIL simul_single: got %b expected %b", obs, exp_v);
      else passed++;
      ev_ready = 1'b1; step(); ev_ready = 1'b0; step();
   endtask

   task automatic test_lockout();
      logic [3:0] pat[5] = '{4'b0001, 4'b1001, 4'b0000, 4'b1000, 4'b0000};
`ifdef BTN_EVT_LOCKOUT_EN
      int         want[$] = '{0, 3};
      logic       want_busy = 1'b1;
`else
      int         want[$] = '{0, 3, 3};
      logic       want_busy = 1'b0;
`endif
      for (int k = 0; k < 5; k++) begin
         btn = pat[k]; step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v)
            $display("FAIL lockout step%0d: got %b expected %b", k, obs, exp_v);
         else passed++;
         if (k == 1) begin
            total++;
            if (busy !== want_busy)
               $display("FAIL lockout_busy: got %b expected %b", busy, want_busy);
            else passed++;
         end
      end
      total++;
      if (ev_count !== 3'(want.size()))
         $display("FAIL lockout_count: got %0d expected %0d", ev_count, want.size());
      else passed++;
      foreach (want[k]) begin
         total++;
         if (ev_valid !== 1'b1 || ev_code !== 2'(want[k]))
            $display("FAIL lockout_pop%0d: got valid=%b code=%0d expected 1/%0d",
                     k, ev_valid, ev_code, want[k]);
         else passed++;
         $display("lockout: pop code=%0d", ev_code);
         ev_ready = 1'b1; step(); ev_ready = 1'b0;
      end
      step();
   endtask

   task automatic test_enable();
      logic [3:0] pat[4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100};
      logic       en[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 4; k++) begin
         btn = pat[k]; enable = en[k]; step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v)
            $display("FAIL enable step%0d: got %b expected %b", k, obs, exp_v);
         else passed++;
         if (k == 1) begin
            total++;
            if (ev_valid !== 1'b0)
               $display("FAIL enable_ignored: got valid=%b expected 0", ev_valid);
            else passed++;
         end
      end
      total++;
      if (ev_valid !== 1'b1 || ev_code !== 2'd2 || ev_count !== 3'd1)
         $display("FAIL enable_repress: got valid=%b code=%0d count=%0d expected 1/2/1",
                  ev_valid, ev_code, ev_count);
      else passed++;
      $display("enable: event code=%0d", ev_code);
      btn = 4'b0000; ev_ready = 1'b1; step(); ev_ready = 1'b0; step();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15));
         enable   = ($urandom_range(0, 7) != 0);
         flush    = ($urandom_range(0, 39) == 0);
         ev_ready = ($urandom_range(0, 2) == 0);
         reset_n  = ($urandom_range(0, 149) != 0);
         step();
         obs = pack_obs(); exp_v = pack_exp();
         total++;
         if (obs !== exp_v) begin
            if (errs < 10)
               $display("FAIL random cyc%0d: got %b expected %b", c, obs, exp_v);
            errs++;
         end else passed++;
      end
      reset_n = 1'b1; flush = 1'b0; enable = 1'b1; ev_ready = 1'b0; btn = 4'b0000;
      $display("random: 600 cycles done");
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow_flush();
      test_simultaneous();
      test_lockout();
      test_enable();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
